// File: rtl/gpo_sched_pkg.sv
// Shared types for the timestamped GPO scheduler: entry layout and FSM encoding.
// Widths here fix the default entry format used by the FIFO and staging register.
package gpo_sched_pkg;

   localparam int TS_W   = 64;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic [TS_W-1:0]   ts;
      logic [DATA_W-1:0] val;
   } gpo_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      FIRE = 2'd3
   } sched_state_t;

endpackage

// File: rtl/gpo_timed_scheduler_if.sv
// Control/data/status bundle between the distribution logic, timer and the scheduler.
// master drives writes, timer and core strobes; slave is the scheduler itself.
interface gpo_timed_scheduler_if #(
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 64,
   parameter int DATA_WIDTH = 64
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                           enable;
   logic                           flush;
   logic                           wr_en;
   logic [TS_WIDTH+DATA_WIDTH-1:0] wr_data;
   logic [TS_WIDTH-1:0]            counter_value;
   logic                           core_busy_error;
   logic                           core_overrided;
   logic                           clear_error;
   logic                           counter_matched;
   logic [TS_WIDTH+DATA_WIDTH-1:0] gpo_in;
   logic                           full;
   logic                           empty;
   logic [CNT_W-1:0]               fifo_count;
   logic                           late_error;
   logic                           overflow_error;
   logic                           busy_error_flag;
   logic                           override_flag;
   logic [15:0]                    late_count;

   modport master (
      output enable, flush, wr_en, wr_data, counter_value,
             core_busy_error, core_overrided, clear_error,
      input  counter_matched, gpo_in, full, empty, fifo_count,
             late_error, overflow_error, busy_error_flag, override_flag, late_count
   );

   modport slave (
      input  enable, flush, wr_en, wr_data, counter_value,
             core_busy_error, core_overrided, clear_error,
      output counter_matched, gpo_in, full, empty, fifo_count,
             late_error, overflow_error, busy_error_flag, override_flag, late_count
   );

endinterface

// File: rtl/gpo_sched_fifo.sv
// Synchronous entry FIFO with occupancy count; writes visible in count next cycle.
// Writes while full are dropped (drop_o); flush empties it and wins over push/pop.
module gpo_sched_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       drop_o
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem[rd_ptr_q];

   // Full is judged before any same-cycle pop, so a write at full is always lost.
   assign push_ok = push_i && !full_o && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;
   assign drop_o  = push_i && full_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/gpo_timed_scheduler.sv
// Timestamped GPO sequencer: buffers entries, fires each when the timer reaches its ts.
// Fire strobe is registered; an already-due entry fires 4 cycles after its write.
module gpo_timed_scheduler
   import gpo_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = TS_W,
   parameter int DATA_WIDTH = DATA_W
) (
   input logic                CLK100MHZ,
   input logic                reset,
   gpo_timed_scheduler_if.slave bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = TS_WIDTH + DATA_WIDTH;

   sched_state_t     state_q, state_d;
   gpo_entry_t       stage_q, stage_d;
   logic             cm_q, cm_d;
   logic             late_error_q, late_error_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             ovr_q, ovr_d;
   logic [15:0]      late_count_q, late_count_d;

   logic [ENT_W-1:0] head;
   logic             fifo_full, fifo_empty, fifo_drop;
   logic [CNT_W-1:0] fifo_count;
   logic             pop, due, late, late_ev;

   gpo_sched_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk     (CLK100MHZ),
      .rst     (reset),
      .flush_i (bus.flush),
      .push_i  (bus.wr_en),
      .pop_i   (pop),
      .wdata_i (bus.wr_data),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .drop_o  (fifo_drop)
   );

   assign due  = (bus.counter_value >= stage_q.ts);
   assign late = (bus.counter_value >  stage_q.ts);

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.enable && !fifo_empty) state_d = LOAD;
            LOAD: state_d = WAIT;
            WAIT: if (bus.enable && due) state_d = FIRE;
            FIRE: state_d = (bus.enable && !fifo_empty) ? LOAD : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A flushed WAIT aborts silently, so it must not count as a late fire either.
   always_comb begin
      pop     = (state_q == LOAD) && !bus.flush;
      late_ev = (state_q == WAIT) && !bus.flush && bus.enable && late;
      cm_d    = (state_d == FIRE);
      stage_d = pop ? gpo_entry_t'(head) : stage_q;
   end

   always_comb begin
      late_error_d = late_ev         | (late_error_q & ~bus.clear_error);
      overflow_d   = fifo_drop       | (overflow_q   & ~bus.clear_error);
      busy_d       = bus.core_busy_error | (busy_q   & ~bus.clear_error);
      ovr_d        = bus.core_overrided  | (ovr_q    & ~bus.clear_error);
      late_count_d = late_count_q;
      if (bus.clear_error)
         late_count_d = late_ev ? 16'd1 : 16'd0;
      else if (late_ev && late_count_q != 16'hFFFF)
         late_count_d = late_count_q + 16'd1;
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         stage_q      <= '0;
         cm_q         <= 1'b0;
         late_error_q <= 1'b0;
         overflow_q   <= 1'b0;
         busy_q       <= 1'b0;
         ovr_q        <= 1'b0;
         late_count_q <= '0;
      end else begin
         stage_q      <= stage_d;
         cm_q         <= cm_d;
         late_error_q <= late_error_d;
         overflow_q   <= overflow_d;
         busy_q       <= busy_d;
         ovr_q        <= ovr_d;
         late_count_q <= late_count_d;
      end
   end

   assign bus.counter_matched = cm_q;
   assign bus.gpo_in          = stage_q;
   assign bus.full            = fifo_full;
   assign bus.empty           = fifo_empty;
   assign bus.fifo_count      = fifo_count;
   assign bus.late_error      = late_error_q;
   assign bus.overflow_error  = overflow_q;
   assign bus.busy_error_flag = busy_q;
   assign bus.override_flag   = ovr_q;
   assign bus.late_count      = late_count_q;

endmodule

// File: tb/tb_gpo_timed_scheduler.sv
// Directed bench for gpo_timed_scheduler: timing, lateness, overflow, flush, async reset.
module tb_gpo_timed_scheduler;
   import gpo_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gpo_timed_scheduler_if #(.FIFO_DEPTH(16), .TS_WIDTH(64), .DATA_WIDTH(64)) bus ();

   gpo_timed_scheduler #(.FIFO_DEPTH(16), .TS_WIDTH(64), .DATA_WIDTH(64)) dut (
      .CLK100MHZ (clk),
      .reset     (rst),
      .bus       (bus)
   );

   logic [63:0] cyc = 64'd0;
   logic [63:0] off = 64'd0;
   always @(posedge clk) cyc <= cyc + 64'd1;
   assign bus.counter_value = cyc + off;

   int total = 0;
   int bad   = 0;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_timer(input logic [63:0] t);
      off = t - cyc;
   endtask

   task automatic wr(input logic [63:0] ts, input logic [63:0] val);
      bus.wr_en   = 1'b1;
      bus.wr_data = {ts, val};
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.clear_error = 1'b1;
      tick();
      bus.clear_error = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] st;
      bus.enable = 1'b0; bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
      bus.core_busy_error = 1'b0; bus.core_overrided = 1'b0; bus.clear_error = 1'b0;
      rst = 1'b1;
      tick(); tick();
      // {empty, full, count[4:0], counter_matched, late_error, overflow_error}
      st = {bus.empty, bus.full, bus.fifo_count, bus.counter_matched, bus.late_error, bus.overflow_error};
      total++;
      if (st !== 10'b10_00000_000) begin
         bad++; $display("FAIL reset_status: got %b want 1000000000", st);
      end
      total++;
      if (bus.gpo_in !== 128'd0 || bus.late_count !== 16'd0) begin
         bad++; $display("FAIL reset_data: gpo_in=%h late_count=%0d want 0/0", bus.gpo_in, bus.late_count);
      end
      total++;
      if (bus.busy_error_flag !== 1'b0 || bus.override_flag !== 1'b0) begin
         bad++; $display("FAIL reset_flags: busy=%b ovr=%b want 0/0", bus.busy_error_flag, bus.override_flag);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_on_time();
      int nfire = 0;
      logic [63:0]  t = '0;
      logic [127:0] v = '0;
      bus.enable = 1'b1;
      set_timer(64'd50);
      wr(64'd100, 64'hA5);
      for (int i = 0; i < 120; i++) begin
         tick();
         if (bus.counter_matched) begin
            nfire++; t = bus.counter_value; v = bus.gpo_in;
         end
      end
      total++;
      if (nfire !== 1) begin bad++; $display("FAIL ontime_count: got %0d want 1", nfire); end
      total++;
      if (t !== 64'd101) begin bad++; $display("FAIL ontime_timer: got %0d want 101", t); end
      total++;
      if (v[63:0] !== 64'hA5) begin bad++; $display("FAIL ontime_val: got %h want a5", v[63:0]); end
      total++;
      if (v[127:64] !== 64'd100) begin bad++; $display("FAIL ontime_ts: got %0d want 100", v[127:64]); end
      total++;
      if (bus.late_error !== 1'b0) begin bad++; $display("FAIL ontime_late: got %b want 0", bus.late_error); end
   endtask

   task automatic test_late();
      set_timer(64'd200);
      wr(64'd10, 64'h5A);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) tick();
         total++;
         if (bus.counter_matched !== (k == 4)) begin
            bad++; $display("FAIL late_latency: cycle %0d got %b want %b", k, bus.counter_matched, k == 4);
         end
      end
      total++;
      if (bus.late_error !== 1'b1 || bus.late_count !== 16'd1) begin
         bad++; $display("FAIL late_flag: late=%b count=%0d want 1/1", bus.late_error, bus.late_count);
      end
      pulse_clear();
      total++;
      if (bus.late_error !== 1'b0 || bus.late_count !== 16'd0) begin
         bad++; $display("FAIL late_clear: late=%b count=%0d want 0/0", bus.late_error, bus.late_count);
      end
   endtask

   task automatic test_overflow();
      logic [63:0] vals [16];
      int n = 0;
      bit seen_dead = 0;
      bus.enable = 1'b0;
      set_timer(64'd1000);
      for (int i = 0; i < 16; i++) wr(64'd5, 64'(i));
      total++;
      if (bus.full !== 1'b1 || bus.fifo_count !== 5'd16 || bus.overflow_error !== 1'b0) begin
         bad++; $display("FAIL ovf_fill: full=%b count=%0d ovf=%b want 1/16/0", bus.full, bus.fifo_count, bus.overflow_error);
      end
      wr(64'd5, 64'hDEAD);
      total++;
      if (bus.full !== 1'b1 || bus.fifo_count !== 5'd16 || bus.overflow_error !== 1'b1) begin
         bad++; $display("FAIL ovf_drop: full=%b count=%0d ovf=%b want 1/16/1", bus.full, bus.fifo_count, bus.overflow_error);
      end
      bus.enable = 1'b1;
      for (int i = 0; i < 120; i++) begin
         tick();
         if (bus.counter_matched) begin
            if (bus.gpo_in[63:0] == 64'hDEAD) seen_dead = 1;
            if (n < 16) vals[n] = bus.gpo_in[63:0];
            n++;
         end
      end
      total++;
      if (n !== 16 || seen_dead) begin
         bad++; $display("FAIL ovf_drain: fires=%0d dropped_seen=%b want 16/0", n, seen_dead);
      end
      for (int i = 0; i < 16 && i < n; i++) begin
         total++;
         if (vals[i] !== 64'(i)) begin bad++; $display("FAIL ovf_order: entry %0d got %h want %h", i, vals[i], i); end
      end
      total++;
      if (bus.empty !== 1'b1 || bus.late_count !== 16'd16) begin
         bad++; $display("FAIL ovf_after: empty=%b late_count=%0d want 1/16", bus.empty, bus.late_count);
      end
      pulse_clear();
      total++;
      if (bus.overflow_error !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow_error); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_t [3] = '{64'd301, 64'd304, 64'd307};
      logic [63:0] t [3];
      logic [63:0] v [3];
      int n = 0;
      set_timer(64'd280);
      wr(64'd300, 64'd1);
      wr(64'd301, 64'd2);
      wr(64'd302, 64'd3);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.counter_matched) begin
            if (n < 3) begin t[n] = bus.counter_value; v[n] = bus.gpo_in[63:0]; end
            n++;
         end
      end
      total++;
      if (n !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", n); end
      for (int i = 0; i < 3 && i < n; i++) begin
         total++;
         if (t[i] !== exp_t[i] || v[i] !== 64'(i + 1)) begin
            bad++; $display("FAIL b2b_fire%0d: timer=%0d val=%0d want %0d/%0d", i, t[i], v[i], exp_t[i], i + 1);
         end
      end
      total++;
      if (bus.late_count !== 16'd2 || bus.late_error !== 1'b1) begin
         bad++; $display("FAIL b2b_late: count=%0d late=%b want 2/1", bus.late_count, bus.late_error);
      end
      pulse_clear();
   endtask

   task automatic test_flush();
      int nfire = 0;
      bit reached = 0;
      set_timer(64'd440);
      wr(64'd500, 64'd7);
      for (int i = 0; i < 40 && !reached; i++) begin
         if (bus.counter_value == 64'd450) reached = 1;
         else tick();
      end
      total++;
      if (!reached || dut.state_q !== WAIT) begin
         bad++; $display("FAIL flush_setup: reached=%b state=%0d want 1/%0d", reached, dut.state_q, WAIT);
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      total++;
      if (dut.state_q !== IDLE || bus.empty !== 1'b1 || bus.fifo_count !== 5'd0) begin
         bad++; $display("FAIL flush_state: state=%0d empty=%b count=%0d want %0d/1/0", dut.state_q, bus.empty, bus.fifo_count, IDLE);
      end
      for (int i = 0; i < 80; i++) begin
         tick();
         if (bus.counter_matched) nfire++;
      end
      total++;
      if (nfire !== 0) begin bad++; $display("FAIL flush_nofire: got %0d fires want 0", nfire); end
      bus.enable  = 1'b0;
      bus.flush   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = {64'd5, 64'd8};
      tick();
      bus.flush = 1'b0;
      bus.wr_en = 1'b0;
      total++;
      if (bus.empty !== 1'b1 || bus.overflow_error !== 1'b0) begin
         bad++; $display("FAIL flush_wr: empty=%b ovf=%b want 1/0", bus.empty, bus.overflow_error);
      end
      bus.enable = 1'b1;
   endtask

   task automatic test_async_reset();
      int nfire = 0;
      set_timer(64'd600);
      wr(64'd640, 64'd9);
      repeat (5) tick();
      total++;
      if (dut.state_q !== WAIT || bus.gpo_in[63:0] !== 64'd9) begin
         bad++; $display("FAIL arst_setup: state=%0d val=%0d want %0d/9", dut.state_q, bus.gpo_in[63:0], WAIT);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.gpo_in !== 128'd0 || bus.empty !== 1'b1 || bus.fifo_count !== 5'd0 || bus.counter_matched !== 1'b0) begin
         bad++; $display("FAIL arst_clear: gpo_in=%h empty=%b count=%0d cm=%b want 0/1/0/0", bus.gpo_in, bus.empty, bus.fifo_count, bus.counter_matched);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (bus.counter_matched) nfire++;
      end
      total++;
      if (nfire !== 0) begin bad++; $display("FAIL arst_nofire: got %0d fires want 0", nfire); end
      bus.core_busy_error = 1'b1;
      tick();
      bus.core_busy_error = 1'b0;
      total++;
      if (bus.busy_error_flag !== 1'b1 || bus.override_flag !== 1'b0) begin
         bad++; $display("FAIL busy_flag: busy=%b ovr=%b want 1/0", bus.busy_error_flag, bus.override_flag);
      end
      bus.core_overrided = 1'b1;
      bus.clear_error    = 1'b1;
      tick();
      bus.core_overrided = 1'b0;
      bus.clear_error    = 1'b0;
      total++;
      if (bus.override_flag !== 1'b1 || bus.busy_error_flag !== 1'b0) begin
         bad++; $display("FAIL clear_vs_event: ovr=%b busy=%b want 1/0", bus.override_flag, bus.busy_error_flag);
      end
   endtask

   initial begin
      test_reset();
      test_on_time();
      test_late();
      test_overflow();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
